fp_align_stage: RTL and testbench
=================================

// Module: fp_align_stage
// PURPOSE
//  FP32 operand-alignment stage that sits directly upstream of SUM_unit in the add/sub datapath.
//  It unpacks two IEEE-754 operands, orders them by magnitude, and right-shifts the smaller mantissa
//  by the exponent difference, keeping guard/round/sticky bits.
//  It emits equal-width aligned mantissas that SUM_unit adds or subtracts, plus the common exponent,
//  result sign, effective-op and special-case info for the normaliser.
//  2-stage pipeline with valid/ready handshake on both sides.
// PARAMETERS
//  EXP_W   8   exponent field width
//  MAN_W   23  stored fraction width
//  GRS_W   3   guard/round/sticky bits appended below the fraction
//  (derived) SIZE_DATA = 1+EXP_W+MAN_W; MANT_W = 1+MAN_W+GRS_W (27 at defaults)
// PORTS
//  i_clk          in   1          clock, rising edge
//  i_rst          in   1          asynchronous, active-high reset
//  i_valid        in   1          operand beat valid
//  o_ready        out  1          stage can accept a beat
//  i_data_a       in   SIZE_DATA  operand A (FP32)
//  i_data_b       in   SIZE_DATA  operand B (FP32)
//  i_sub          in   1          1 = A-B, 0 = A+B
//  o_valid        out  1          output beat valid
//  i_ready        in   1          downstream (SUM_unit wrapper) accepts beat
//  o_mant_big     out  MANT_W     larger-magnitude mantissa {hidden,frac,GRS=0}
//  o_mant_small   out  MANT_W     smaller mantissa, aligned; LSB = sticky
//  o_exp          out  EXP_W      common (larger) biased exponent
//  o_sign         out  1          result sign
//  o_eff_sub      out  1          1 = SUM_unit must compute big-small
//  o_special      out  1          result is NaN/Inf; use o_special_val
//  o_special_val  out  SIZE_DATA  final result for special cases
// BEHAVIOUR
//  Reset: all outputs and internal valids go to 0 immediately on i_rst=1; in-flight beats are discarded.
//  Handshake: a beat transfers when valid&ready are high at a rising edge.
//   o_ready = !s1_valid | s2_adv, where s2_adv = !o_valid | i_ready.
//   Output data is held stable while o_valid=1 and i_ready=0.
//   Latency is 2 cycles with i_ready=1; throughput is 1 beat/cycle; no bubbles are inserted.
//  Stage 1 (register):
//   - Unpack both operands. A zero exponent field gives hidden=0 and effective exponent 1 (denormal).
//   - Effective sign of B = sign_b ^ i_sub; eff_sub = sign_a ^ effective sign of B.
//   - A is the big operand iff {exp_a,frac_a} >= {exp_b,frac_b}; otherwise swap. A tie selects A.
//   - diff = eff_exp_big - eff_exp_small (unsigned, EXP_W bits).
//  Stage 2 (register):
//   - o_mant_small = {hid,frac,000} >> diff. Sticky (LSB) = OR of every bit shifted out plus the existing LSB.
//   - If diff >= MANT_W: o_mant_small = {0...,sticky}, with sticky = |mantissa.
//   - o_sign = sign of big (effective sign for B).
//     Exception: eff_sub with equal magnitudes gives o_sign=0 (RNE +0).
//  Specials (evaluated in stage 1, carried through):
//   - Any NaN, or Inf-Inf with eff_sub: o_special=1, o_special_val=0x7FC00000.
//   - Otherwise, any Inf: o_special=1, o_special_val=Inf carrying that operand's effective sign.
//   - When o_special=0, o_special_val=0.
//   - Mantissa fields are don't-care when o_special=1 but must not be X.
// TESTING
//  1. A=0x3F800000 B=0x3F800000 sub=0 -> after 2 clk:
//     exp=127, big=small=0x4000000, eff_sub=0, sign=0.
//  2. A=0x3F800000 B=0x3F000000 sub=0 -> small=0x2000000, big=0x4000000, exp=127.
//  3. A=0x3F800000 B=0x30800000 (diff 30) sub=0 -> small=0x0000001 (sticky only).
//  4. A=0x3F000000 B=0xBF800000 sub=0 -> swap:
//     big=0x4000000, small=0x2000000, exp=127, sign=1, eff_sub=1.
//  5. Stream 4 beats with i_ready=0 for 3 cycles:
//     o_ready drops once 2 beats are held, o_valid/o_* stay stable, no beat is lost or duplicated.
//  6. A=0x7F800000 B=0x7F800000 sub=1 -> special=1, val=0x7FC00000.
//     Assert i_rst with beats in flight -> o_valid=0 same cycle.

Source files
------------

// File: rtl/fp_align_stage.sv
// FP32 add/sub operand-alignment stage: unpack, order by magnitude, align the smaller
// mantissa with guard/round/sticky, and flag NaN/Inf results. Two registered stages, valid/ready.
module fp_align_stage #(
  parameter  int EXP_W     = 8,
  parameter  int MAN_W     = 23,
  parameter  int GRS_W     = 3,
  localparam int SIZE_DATA = 1 + EXP_W + MAN_W,
  localparam int MANT_W    = 1 + MAN_W + GRS_W
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [SIZE_DATA-1:0] i_data_a,
  input  logic [SIZE_DATA-1:0] i_data_b,
  input  logic                 i_sub,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [MANT_W-1:0]    o_mant_big,
  output logic [MANT_W-1:0]    o_mant_small,
  output logic [EXP_W-1:0]     o_exp,
  output logic                 o_sign,
  output logic                 o_eff_sub,
  output logic                 o_special,
  output logic [SIZE_DATA-1:0] o_special_val
);

  localparam logic [SIZE_DATA-1:0] QNAN =
    {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  // ---------------- stage 1: unpack, compare, specials ----------------
  logic                 sign_a, sign_b_eff, eff_sub;
  logic [EXP_W-1:0]     exp_a, exp_b, eexp_a, eexp_b;
  logic [MAN_W-1:0]     frac_a, frac_b;
  logic [MANT_W-1:0]    mant_a, mant_b;
  logic                 a_big, same_mag;
  logic                 nan_a, nan_b, inf_a, inf_b;
  logic                 special_d;
  logic [SIZE_DATA-1:0] special_val_d;

  assign sign_a     = i_data_a[SIZE_DATA-1];
  assign sign_b_eff = i_data_b[SIZE_DATA-1] ^ i_sub;
  assign exp_a      = i_data_a[SIZE_DATA-2 -: EXP_W];
  assign exp_b      = i_data_b[SIZE_DATA-2 -: EXP_W];
  assign frac_a     = i_data_a[MAN_W-1:0];
  assign frac_b     = i_data_b[MAN_W-1:0];
  assign eff_sub    = sign_a ^ sign_b_eff;

  // Denormals: hidden bit 0 and an effective exponent of 1.
  assign eexp_a = (exp_a == '0) ? EXP_W'(1) : exp_a;
  assign eexp_b = (exp_b == '0) ? EXP_W'(1) : exp_b;
  assign mant_a = {|exp_a, frac_a, {GRS_W{1'b0}}};
  assign mant_b = {|exp_b, frac_b, {GRS_W{1'b0}}};

  assign a_big    = {exp_a, frac_a} >= {exp_b, frac_b};
  assign same_mag = {exp_a, frac_a} == {exp_b, frac_b};

  assign nan_a = (&exp_a) && (frac_a != '0);
  assign nan_b = (&exp_b) && (frac_b != '0);
  assign inf_a = (&exp_a) && (frac_a == '0);
  assign inf_b = (&exp_b) && (frac_b == '0);

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    special_d     = 1'b0;
    special_val_d = '0;
    if (nan_a || nan_b || (inf_a && inf_b && eff_sub)) begin
      special_d     = 1'b1;
      special_val_d = QNAN;
    end else if (inf_a) begin
      special_d     = 1'b1;
      special_val_d = {sign_a, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end else if (inf_b) begin
      special_d     = 1'b1;
      special_val_d = {sign_b_eff, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
    end
  end

  logic                 s1_valid, s1_sign, s1_eff_sub, s1_special;
  logic [MANT_W-1:0]    s1_big, s1_small;
  logic [EXP_W-1:0]     s1_exp, s1_diff;
  logic [SIZE_DATA-1:0] s1_special_val;
  logic                 s2_adv;

  assign s2_adv  = !o_valid || i_ready;
  assign o_ready = !s1_valid || s2_adv;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid       <= 1'b0;
      s1_big         <= '0;
      s1_small       <= '0;
      s1_exp         <= '0;
      s1_diff        <= '0;
      s1_sign        <= 1'b0;
      s1_eff_sub     <= 1'b0;
      s1_special     <= 1'b0;
      s1_special_val <= '0;
    end else if (o_ready) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        s1_big         <= a_big ? mant_a : mant_b;
        s1_small       <= a_big ? mant_b : mant_a;
        // o_exp is the effective exponent, so a denormal big operand reports 1.
        s1_exp         <= a_big ? eexp_a : eexp_b;
        s1_diff        <= a_big ? (eexp_a - eexp_b) : (eexp_b - eexp_a);
        // Exact cancellation rounds to +0 under round-to-nearest-even.
        s1_sign        <= (eff_sub && same_mag) ? 1'b0 : (a_big ? sign_a : sign_b_eff);
        s1_eff_sub     <= eff_sub;
        s1_special     <= special_d;
        s1_special_val <= special_val_d;
      end
    end
  end

  // ---------------- stage 2: align smaller mantissa ----------------
  logic [MANT_W-1:0] shifted, lost_mask, small_aligned;

  always_comb begin
    shifted   = s1_small >> s1_diff;
    lost_mask = ~({MANT_W{1'b1}} << s1_diff);
    if (int'(s1_diff) >= MANT_W)
      small_aligned = {{(MANT_W-1){1'b0}}, |s1_small};
    else
      small_aligned = {shifted[MANT_W-1:1], shifted[0] | (|(s1_small & lost_mask))};
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid       <= 1'b0;
      o_mant_big    <= '0;
      o_mant_small  <= '0;
      o_exp         <= '0;
      o_sign        <= 1'b0;
      o_eff_sub     <= 1'b0;
      o_special     <= 1'b0;
      o_special_val <= '0;
    end else if (s2_adv) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_mant_big    <= s1_big;
        o_mant_small  <= small_aligned;
        o_exp         <= s1_exp;
        o_sign        <= s1_sign;
        o_eff_sub     <= s1_eff_sub;
        o_special     <= s1_special;
        o_special_val <= s1_special_val;
      end
    end
  end

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed bench for fp_align_stage: single beats with hand-computed results,
// backpressure streaming, and asynchronous reset with beats in flight.
module tb_fp_align_stage;

  logic        i_clk, i_rst, i_valid, o_ready, i_sub, o_valid, i_ready;
  logic [31:0] i_data_a, i_data_b, o_special_val;
  logic [26:0] o_mant_big, o_mant_small;
  logic [7:0]  o_exp;
  logic        o_sign, o_eff_sub, o_special;

  int n_total = 0;
  int n_bad   = 0;

  fp_align_stage dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_valid      (i_valid),
    .o_ready      (o_ready),
    .i_data_a     (i_data_a),
    .i_data_b     (i_data_b),
    .i_sub        (i_sub),
    .o_valid      (o_valid),
    .i_ready      (i_ready),
    .o_mant_big   (o_mant_big),
    .o_mant_small (o_mant_small),
    .o_exp        (o_exp),
    .o_sign       (o_sign),
    .o_eff_sub    (o_eff_sub),
    .o_special    (o_special),
    .o_special_val(o_special_val)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One beat in, two edges later compare every output field.
  task automatic run_vec(input string tag, input logic [31:0] a, input logic [31:0] b,
                         input logic sub, input logic [26:0] e_big, input logic [26:0] e_small,
                         input logic [7:0] e_exp, input logic e_sign, input logic e_eff,
                         input logic e_spec, input logic [31:0] e_sval);
    @(negedge i_clk);
    i_ready  = 1'b1;
    i_data_a = a;
    i_data_b = b;
    i_sub    = sub;
    i_valid  = 1'b1;
    #1 check({tag, ".in_ready"}, 32'(o_ready), 32'd1);
    @(negedge i_clk);
    i_valid = 1'b0;
    @(negedge i_clk);
    check({tag, ".valid"}, 32'(o_valid), 32'd1);
    check({tag, ".special"}, 32'(o_special), 32'(e_spec));
    check({tag, ".special_val"}, o_special_val, e_sval);
    check({tag, ".eff_sub"}, 32'(o_eff_sub), 32'(e_eff));
    if (!e_spec) begin
      check({tag, ".big"}, 32'(o_mant_big), 32'(e_big));
      check({tag, ".small"}, 32'(o_mant_small), 32'(e_small));
      check({tag, ".exp"}, 32'(o_exp), 32'(e_exp));
      check({tag, ".sign"}, 32'(o_sign), 32'(e_sign));
    end
  endtask

  logic [31:0] strm_b   [4] = '{32'h3F800000, 32'h3F000000, 32'h3E800000, 32'h3E000000};
  logic [26:0] strm_exp [4] = '{27'h4000000, 27'h2000000, 27'h1000000, 27'h0800000};
  logic [26:0] got_q [$];

  initial begin
    i_rst    = 1'b1;
    i_valid  = 1'b0;
    i_ready  = 1'b1;
    i_sub    = 1'b0;
    i_data_a = '0;
    i_data_b = '0;
    repeat (2) @(negedge i_clk);
    check("rst.valid", 32'(o_valid), 32'd0);
    check("rst.ready", 32'(o_ready), 32'd1);
    check("rst.big", 32'(o_mant_big), 32'd0);
    check("rst.special_val", o_special_val, 32'd0);
    i_rst = 1'b0;

    //        tag       A             B             sub   big           small         exp  sgn eff spc val
    run_vec("one+one",  32'h3F800000, 32'h3F800000, 1'b0, 27'h4000000, 27'h4000000, 8'd127, 0, 0, 0, 32'h0);
    run_vec("one+half", 32'h3F800000, 32'h3F000000, 1'b0, 27'h4000000, 27'h2000000, 8'd127, 0, 0, 0, 32'h0);
    run_vec("diff30",   32'h3F800000, 32'h30800000, 1'b0, 27'h4000000, 27'h0000001, 8'd127, 0, 0, 0, 32'h0);
    run_vec("swap",     32'h3F000000, 32'hBF800000, 1'b0, 27'h4000000, 27'h2000000, 8'd127, 1, 1, 0, 32'h0);
    run_vec("diff4stk", 32'h41800000, 32'h3F800001, 1'b0, 27'h4000000, 27'h0400001, 8'd131, 0, 0, 0, 32'h0);
    run_vec("diff25",   32'h3F800000, 32'h33000000, 1'b0, 27'h4000000, 27'h0000002, 8'd127, 0, 0, 0, 32'h0);
    run_vec("diff27",   32'h3F800000, 32'h32000000, 1'b0, 27'h4000000, 27'h0000001, 8'd127, 0, 0, 0, 32'h0);
    run_vec("plus0",    32'h3F800000, 32'h00000000, 1'b0, 27'h4000000, 27'h0000000, 8'd127, 0, 0, 0, 32'h0);
    run_vec("x-x",      32'h3F800000, 32'h3F800000, 1'b1, 27'h4000000, 27'h4000000, 8'd127, 0, 1, 0, 32'h0);
    run_vec("nx-nx",    32'hBF800000, 32'hBF800000, 1'b1, 27'h4000000, 27'h4000000, 8'd127, 0, 1, 0, 32'h0);
    run_vec("inf-inf",  32'h7F800000, 32'h7F800000, 1'b1, 27'h0,       27'h0,       8'd0,   0, 1, 1, 32'h7FC00000);
    run_vec("inf+inf",  32'h7F800000, 32'h7F800000, 1'b0, 27'h0,       27'h0,       8'd0,   0, 0, 1, 32'h7F800000);
    run_vec("one-inf",  32'h3F800000, 32'h7F800000, 1'b1, 27'h0,       27'h0,       8'd0,   0, 1, 1, 32'hFF800000);
    run_vec("nan",      32'h3F800000, 32'h7F800001, 1'b0, 27'h0,       27'h0,       8'd0,   0, 0, 1, 32'h7FC00000);

    // Stream 4 beats; i_ready low for the first 5 cycles so the pipe fills and holds for 3.
    begin
      int sent = 0;
      int extra = 0;
      for (int c = 0; c < 40 && got_q.size() < 4; c++) begin
        @(negedge i_clk);
        i_ready = (c >= 5);
        if (sent < 4) begin
          i_valid  = 1'b1;
          i_data_a = 32'h3F800000;
          i_data_b = strm_b[sent];
          i_sub    = 1'b0;
        end else begin
          i_valid = 1'b0;
        end
        #1;
        if (c >= 2 && c <= 4) begin
          check($sformatf("stall%0d.ready", c), 32'(o_ready), 32'd0);
          check($sformatf("stall%0d.valid", c), 32'(o_valid), 32'd1);
          check($sformatf("stall%0d.small", c), 32'(o_mant_small), 32'h4000000);
        end
        if (i_valid && o_ready) sent++;
        if (o_valid && i_ready) got_q.push_back(o_mant_small);
      end
      i_valid = 1'b0;
      repeat (3) begin
        @(negedge i_clk);
        #1 if (o_valid && i_ready) extra++;
      end
      check("stream.count", 32'(got_q.size()), 32'd4);
      check("stream.extra", 32'(extra), 32'd0);
      for (int k = 0; k < 4; k++)
        check($sformatf("stream.beat%0d", k),
              (k < got_q.size()) ? 32'(got_q[k]) : 32'hFFFFFFFF, 32'(strm_exp[k]));
    end

    // Asynchronous reset with two beats in flight.
    @(negedge i_clk);
    i_ready  = 1'b1;
    i_data_a = 32'h3F800000;
    i_data_b = 32'h3F000000;
    i_valid  = 1'b1;
    @(negedge i_clk);
    @(negedge i_clk);
    check("flight.valid", 32'(o_valid), 32'd1);
    i_rst = 1'b1;
    #1;
    check("arst.valid", 32'(o_valid), 32'd0);
    check("arst.big", 32'(o_mant_big), 32'd0);
    i_valid = 1'b0;
    @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    check("arst.drained", 32'(o_valid), 32'd0);
    run_vec("post_rst", 32'h3F800000, 32'h3F000000, 1'b0, 27'h4000000, 27'h2000000, 8'd127, 0, 0, 0, 32'h0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
